// File: rtl/ika9958_st_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ika9958_st_pkg
//  Description : Shared line constants, latched-mode type and frame geometry
//                helpers for the vertical screen-timing generator.
//                  NTSC/PAL frame lengths (progressive and per interlace field)
//                  sync length, active-window start bases and active lengths
//                  st_mode_t : {pal, ln, il, adjv} shadow of the mode inputs
//  Revision    : 1.0  initial release
// ============================================================================
package ika9958_st_pkg;

   localparam int unsigned VCNT_W           = 9;

   localparam int unsigned NTSC_LINES       = 262;
   localparam int unsigned PAL_LINES        = 313;
   localparam int unsigned NTSC_IL_F0_LINES = 263;
   localparam int unsigned NTSC_IL_F1_LINES = 262;
   localparam int unsigned PAL_IL_F0_LINES  = 313;
   localparam int unsigned PAL_IL_F1_LINES  = 312;

   localparam int unsigned VSYNC_LINES      = 3;

   localparam int unsigned VSTART_NTSC_192  = 40;
   localparam int unsigned VSTART_NTSC_212  = 30;
   localparam int unsigned VSTART_PAL_192   = 67;
   localparam int unsigned VSTART_PAL_212   = 57;

   localparam int unsigned ACTIVE_192       = 192;
   localparam int unsigned ACTIVE_212       = 212;

   typedef logic [VCNT_W-1:0] vline_t;

   typedef struct packed {
      logic       pal;
      logic       ln;
      logic       il;
      logic [3:0] adjv;
   } st_mode_t;

   // Number of lines in the frame/field described by the mode and field bit.
   function automatic vline_t frame_len(input st_mode_t m, input logic field);
      vline_t len;
      if (m.pal) begin
         if (m.il) len = field ? vline_t'(PAL_IL_F1_LINES) : vline_t'(PAL_IL_F0_LINES);
         else      len = vline_t'(PAL_LINES);
      end else begin
         if (m.il) len = field ? vline_t'(NTSC_IL_F1_LINES) : vline_t'(NTSC_IL_F0_LINES);
         else      len = vline_t'(NTSC_LINES);
      end
      return len;
   endfunction

   // First active line: standard/line-count base plus the signed adjust.
   // 9-bit modular add of the sign-extended nibble gives base-8..base+7.
   function automatic vline_t vstart_of(input st_mode_t m);
      vline_t base;
      case ({m.pal, m.ln})
         2'b00:   base = vline_t'(VSTART_NTSC_192);
         2'b01:   base = vline_t'(VSTART_NTSC_212);
         2'b10:   base = vline_t'(VSTART_PAL_192);
         default: base = vline_t'(VSTART_PAL_212);
      endcase
      return base + {{(VCNT_W-4){m.adjv[3]}}, m.adjv};
   endfunction

   // First line after the active window.
   function automatic vline_t vend_of(input st_mode_t m);
      return vstart_of(m) + (m.ln ? vline_t'(ACTIVE_212) : vline_t'(ACTIVE_192));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ika9958_st_edgedet.sv
`default_nettype none
// ============================================================================
//  Module      : ika9958_st_edgedet
//  Description : Two-flop synchroniser followed by a falling-edge detector.
//                All flops idle high, so a signal held low through reset
//                produces one edge once reset is released.
//  Ports       : clk_i   clock, rising edge
//                rst_n_i synchronous active-low reset (ignores cen_i)
//                cen_i   clock enable
//                d_i     asynchronous input
//                fall_o  high for one enabled period after a 1->0 transition
//  Revision    : 1.0  initial release
// ============================================================================
module ika9958_st_edgedet (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic cen_i,
   input  logic d_i,
   output logic fall_o
);

   // [0],[1] : synchroniser stages, [2] : previous synchronised value
   logic [2:0] sh_q;
   logic [2:0] sh_d;

   assign sh_d = {sh_q[1:0], d_i};

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sh_q <= 3'b111;
      end else if (cen_i) begin
         sh_q <= sh_d;
      end
   end

   assign fall_o = sh_q[2] & ~sh_q[1];

endmodule
`default_nettype wire

// File: rtl/ika9958_st_vtiming.sv
`default_nettype none
// ============================================================================
//  Module      : ika9958_st_vtiming
//  Description : Vertical screen-timing generator. Advances the line counter
//                on each end-of-line pulse from the horizontal stage and
//                derives sync, blanking, scrolled display line, interrupt
//                pulses and the external-HRST acceptance window.
//  Ports       : i_phiA       master clock
//                i_RST_n      synchronous active-low reset (ignores enable)
//                i_phiL_NCEN  clock enable, state advances when high
//                i_HEND       end-of-line pulse
//                i_VRST_n     external vertical reset, asynchronous
//                i_PAL/i_LN/i_IL/i_ADJV  mode inputs, latched at frame wrap
//                i_VSCR       vertical scroll (live)
//                i_LINT       line-interrupt compare value
//                o_VCNT o_DLINE o_VSYNC o_VBLANK o_FIELD o_VINT o_LINT
//                o_HRST_EN    registered timing outputs
//  Revision    : 1.0  initial release
// ============================================================================
module ika9958_st_vtiming
   import ika9958_st_pkg::*;
(
   input  logic       i_phiA,
   input  logic       i_RST_n,
   input  logic       i_phiL_NCEN,
   input  logic       i_HEND,
   input  logic       i_VRST_n,
   input  logic       i_PAL,
   input  logic       i_LN,
   input  logic       i_IL,
   input  logic [3:0] i_ADJV,
   input  logic [7:0] i_VSCR,
   input  logic [7:0] i_LINT,
   output logic [8:0] o_VCNT,
   output logic [7:0] o_DLINE,
   output logic       o_VSYNC,
   output logic       o_VBLANK,
   output logic       o_FIELD,
   output logic       o_VINT,
   output logic       o_LINT,
   output logic       o_HRST_EN
);

   st_mode_t mode_in;
   st_mode_t mode_q, mode_d;
   vline_t   vcnt_q, vcnt_d;
   logic     field_q, field_d;
   logic     pending_q, pending_d;
   logic     vrst_fall;

   logic [7:0] dline_q, dline_d;
   logic       vsync_q, vsync_d;
   logic       vblank_q, vblank_d;
   logic       hrst_en_q, hrst_en_d;
   logic       vint_q, vint_d;
   logic       lint_q, lint_d;

   vline_t   cur_len;
   logic     at_last_line;
   vline_t   nxt_vstart;
   vline_t   nxt_vend;
   vline_t   nxt_len;
   vline_t   dline_sum;
   logic     in_active;

   assign mode_in = '{pal: i_PAL, ln: i_LN, il: i_IL, adjv: i_ADJV};

   ika9958_st_edgedet u_vrst_edge (
      .clk_i   (i_phiA),
      .rst_n_i (i_RST_n),
      .cen_i   (i_phiL_NCEN),
      .d_i     (i_VRST_n),
      .fall_o  (vrst_fall)
   );

   // Wrap decision uses the geometry of the frame currently being scanned.
   assign cur_len      = frame_len(mode_q, field_q);
   assign at_last_line = (vcnt_q == cur_len - 9'd1);

   // ---------------------------------------------------------------------
   // Line counter, mode shadow, field and pending external reset
   // ---------------------------------------------------------------------
   always_comb begin
      vcnt_d    = vcnt_q;
      mode_d    = mode_q;
      field_d   = field_q;
      pending_d = pending_q | vrst_fall;

      if (i_HEND) begin
         // A fall arriving on this very line end is kept for the next one.
         pending_d = vrst_fall;
         if (pending_q || at_last_line) begin
            vcnt_d = '0;
            mode_d = mode_in;
            if (!mode_in.il) begin
               field_d = 1'b0;
            end else if (!pending_q) begin
               field_d = ~field_q;
            end
         end else begin
            vcnt_d = vcnt_q + 9'd1;
         end
      end
   end

   // Outputs describe the line being entered, so use the post-wrap geometry.
   assign nxt_vstart = vstart_of(mode_d);
   assign nxt_vend   = vend_of(mode_d);
   assign nxt_len    = frame_len(mode_d, field_d);
   assign dline_sum  = vcnt_d - nxt_vstart + {1'b0, i_VSCR};
   assign in_active  = (vcnt_d >= nxt_vstart) && (vcnt_d < nxt_vend);

   // ---------------------------------------------------------------------
   // Registered outputs; interrupt pulses clear on every enabled edge
   // ---------------------------------------------------------------------
   always_comb begin
      dline_d   = dline_q;
      vsync_d   = vsync_q;
      vblank_d  = vblank_q;
      hrst_en_d = hrst_en_q;
      vint_d    = 1'b0;
      lint_d    = 1'b0;

      if (i_HEND) begin
         dline_d   = dline_sum[7:0];
         vsync_d   = (vcnt_d < vline_t'(VSYNC_LINES));
         vblank_d  = ~in_active;
         hrst_en_d = (vcnt_d < vline_t'(VSYNC_LINES)) || (vcnt_d == nxt_len - 9'd1);
         vint_d    = (vcnt_d == nxt_vend);
         lint_d    = in_active && (dline_sum[7:0] == i_LINT);
      end
   end

   always_ff @(posedge i_phiA) begin
      if (!i_RST_n) begin
         vcnt_q    <= '0;
         mode_q    <= mode_in;
         field_q   <= 1'b0;
         pending_q <= 1'b0;
         dline_q   <= '0;
         vsync_q   <= 1'b1;
         vblank_q  <= 1'b1;
         hrst_en_q <= 1'b1;
         vint_q    <= 1'b0;
         lint_q    <= 1'b0;
      end else if (i_phiL_NCEN) begin
         vcnt_q    <= vcnt_d;
         mode_q    <= mode_d;
         field_q   <= field_d;
         pending_q <= pending_d;
         dline_q   <= dline_d;
         vsync_q   <= vsync_d;
         vblank_q  <= vblank_d;
         hrst_en_q <= hrst_en_d;
         vint_q    <= vint_d;
         lint_q    <= lint_d;
      end
   end

   assign o_VCNT    = vcnt_q;
   assign o_DLINE   = dline_q;
   assign o_VSYNC   = vsync_q;
   assign o_VBLANK  = vblank_q;
   assign o_FIELD   = field_q;
   assign o_VINT    = vint_q;
   assign o_LINT    = lint_q;
   assign o_HRST_EN = hrst_en_q;

endmodule
`default_nettype wire
